imu_poll_ctrl: RTL
==================

Name: imu_poll_ctrl

Overview:
- Sits directly downstream of jb_imu and paces it.
- Issues a one-cycle start to jb_imu at a fixed poll rate and waits for its done.
- On done, latches the attitude/rate/accel frame into a stable, sequence-numbered register set for the flight-control logic.
- Detects IMU timeouts and poll overruns, and raises a fault after repeated failures.

Parameters:
- POLL_DIV, 250000: clock cycles per poll period (200 Hz at the 50 MHz clock).
- TIMEOUT_CYC, 100000: maximum cycles from start to done before the poll is abandoned.
- MAX_FAIL, 3: consecutive timeouts that assert fault.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable.
- imu_done  in  1  jb_imu done; completion is its rising edge.
- imu_att  in  48  jb_imu {roll,pitch,yaw}, 16 bits each.
- imu_rate  in  48  jb_imu {roll_rate,pitch_rate,yaw_rate}.
- imu_accel  in  48  jb_imu {accel_x,accel_y,accel_z}.
- imu_start  out  1  one-cycle start pulse to jb_imu.
- att  out  48  latched attitude.
- rate  out  48  latched rates.
- accel  out  48  latched accelerations.
- sample_valid  out  1  one-cycle pulse when a new frame is latched.
- sample_seq  out  8  frame sequence number, mod 256.
- timeout_pulse  out  1  one-cycle pulse when a poll is abandoned.
- overrun  out  1  one-cycle pulse when a poll tick lands while busy.
- fault  out  1  level; consecutive failures have reached MAX_FAIL.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Period, timeout and fail counters clear.
  - done_d clears.
  - All outputs are 0.
- Period counter:
  - Held at 0 while enable=0.
  - While enable=1 it counts 0..POLL_DIV-1 and wraps.
  - tick asserts in the cycle the counter equals POLL_DIV-1.
  - First imu_start rises POLL_DIV cycles after enable is first sampled high.
- Edge detect: done_d registers imu_done every cycle in all states. done_rise = imu_done & ~done_d.
- FSM states and transitions:
  - IDLE: on tick with enable=1, go to START.
  - START: imu_start=1 for exactly this cycle; timeout counter clears; go to WAIT.
  - WAIT, normal completion: timeout counter increments each cycle. On done_rise, in the same clock edge:
    - att/rate/accel capture the imu_* inputs.
    - sample_valid pulses in the following cycle.
    - sample_seq increments, 255 wraps to 0.
    - fail counter clears and fault deasserts.
    - go to IDLE.
  - WAIT, timeout: if the timeout counter reaches TIMEOUT_CYC-1 without done_rise:
    - timeout_pulse for one cycle.
    - fail counter increments, saturating at MAX_FAIL.
    - fault=1 once fail counter == MAX_FAIL.
    - outputs keep their last frame.
    - go to IDLE.
- Simultaneous done_rise and timeout terminal count: done wins; no timeout_pulse.
- tick in START or WAIT: overrun pulses for one cycle; the tick is dropped, not queued; no extra imu_start.
- done_rise in IDLE or START: ignored; no latch, no valid.
- enable deasserted in WAIT: the transaction completes or times out normally; no further starts while enable=0.
- imu_start is never asserted twice without an intervening done_rise or timeout.
- Latency: done_rise to sample_valid high is 1 cycle; latched data is valid in the same cycle sample_valid is high.

Optional Feature:
- Macro: IMU_TIMESTAMP_EN.
- Defined:
  - adds output sample_ts (32 bits).
  - adds a free-running 32-bit cycle counter, cleared by reset, that wraps at 2^32.
  - sample_ts captures the counter value at the clock edge that latches the frame.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Nominal: POLL_DIV=100, TIMEOUT_CYC=50, model raises done 20 cycles after start.
  - imu_start is 1 cycle wide, every 100 cycles.
  - sample_valid follows 1 cycle after each done rise, with att/rate/accel equal to model data (e.g. att=48'h0001_0002_0003).
  - sample_seq runs 1,2,3.
- Timeout/fault: model never responds.
  - timeout_pulse 50 cycles after each start.
  - fault=1 after the 3rd timeout.
  - Model then responds: fault=0, sample_valid pulses, sample_seq increments by 1.
- Overrun: TIMEOUT_CYC=200, done delayed 150 cycles.
  - overrun pulses at the tick 100 cycles after start.
  - No second imu_start; frame still latches at 150.
- Enable/reset mid-WAIT:
  - Drop enable 10 cycles after start: frame still latched, no further imu_start.
  - Assert reset mid-WAIT: all outputs 0 immediately; a later done is ignored.
  - After reset releases with enable=1, first start comes 100 cycles later.
- Edge cases:
  - 256 successful polls: sample_seq wraps 255→0.
  - done held high across two polls: only the first rising edge latches.
  - done pulse in IDLE: no sample_valid.
  - With IMU_TIMESTAMP_EN defined: sample_ts deltas equal 100.

Source files
------------

// File: rtl/imu_poll_ctrl.sv
// Poll pacer for jb_imu: periodic start, frame latch with sequence number, timeout/overrun/fault tracking.
// Build option IMU_TIMESTAMP_EN adds a free-running cycle counter and the sample_ts output.
module imu_poll_ctrl #(
    parameter int POLL_DIV    = 250000,
    parameter int TIMEOUT_CYC = 100000,
    parameter int MAX_FAIL    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        imu_done,
    input  logic [47:0] imu_att,
    input  logic [47:0] imu_rate,
    input  logic [47:0] imu_accel,
    output logic        imu_start,
    output logic [47:0] att,
    output logic [47:0] rate,
    output logic [47:0] accel,
    output logic        sample_valid,
    output logic [7:0]  sample_seq,
    output logic        timeout_pulse,
    output logic        overrun,
    output logic        fault
`ifdef IMU_TIMESTAMP_EN
    ,
    output logic [31:0] sample_ts
`endif
);

    localparam int PD_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int FL_W = $clog2(MAX_FAIL + 1);

    localparam logic [PD_W-1:0] PD_LAST = PD_W'(POLL_DIV - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [FL_W-1:0] FL_MAX  = FL_W'(MAX_FAIL);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PD_W-1:0] per_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [FL_W-1:0] fail_cnt;
    logic            done_d;
    logic            done_rise;
    logic            tick;
    logic            latch_p0;
    logic            abandon_p0;
    logic            ovr_p0;

    function automatic logic [FL_W-1:0] sat_inc(input logic [FL_W-1:0] v);
        return (v >= FL_MAX) ? FL_MAX : v + FL_W'(1);
    endfunction

    assign tick      = enable && (per_cnt == PD_LAST);
    assign done_rise = imu_done && !done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
            done_d  <= 1'b0;
            state   <= IDLE;
        end else begin
            done_d <= imu_done;
            state  <= state_nxt;
            if (!enable || per_cnt == PD_LAST)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + PD_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        latch_p0   = 1'b0;
        abandon_p0 = 1'b0;
        case (state)
            IDLE:  if (tick) state_nxt = START;
            START: state_nxt = WAIT;
            WAIT: begin
                // done wins over a coincident timeout terminal count
                if (done_rise) begin
                    latch_p0  = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    abandon_p0 = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            to_cnt <= '0;
        else if (state == START)
            to_cnt <= '0;
        else if (state == WAIT)
            to_cnt <= to_cnt + TO_W'(1);
    end

    // output stage: registered pulses and the latched frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imu_start     <= 1'b0;
            sample_valid  <= 1'b0;
            timeout_pulse <= 1'b0;
            ovr_p0        <= 1'b0;
            overrun       <= 1'b0;
            att           <= '0;
            rate          <= '0;
            accel         <= '0;
            sample_seq    <= '0;
            fail_cnt      <= '0;
            fault         <= 1'b0;
        end else begin
            imu_start     <= (state == START);
            sample_valid  <= latch_p0;
            timeout_pulse <= abandon_p0;
            // overrun lines up with the edge where the dropped start would have risen
            ovr_p0        <= tick && (state != IDLE);
            overrun       <= ovr_p0;
            if (latch_p0) begin
                att        <= imu_att;
                rate       <= imu_rate;
                accel      <= imu_accel;
                sample_seq <= sample_seq + 8'd1;
                fail_cnt   <= '0;
                fault      <= 1'b0;
            end else if (abandon_p0) begin
                fail_cnt <= sat_inc(fail_cnt);
                fault    <= (sat_inc(fail_cnt) == FL_MAX);
            end
        end
    end

`ifdef IMU_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_cnt    <= '0;
            sample_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (latch_p0)
                sample_ts <= ts_cnt;
        end
    end
`endif

endmodule
